// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared constants for the bit-serial subtractor
//
// Purpose: FSM state encoding and legal WIDTH bounds, imported by the
// serial_subtractor top level.
// Ports: none (package).

package serial_sub_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Legal operand width range
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell
//
// Purpose: combinational one-bit subtract x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // A borrow is produced when y exceeds x, or when x == y and a borrow
  // is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor
//
// Purpose: computes a - b one bit per clock through a single full
// subtractor cell, LSB first, and holds the result on registered outputs.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a subtraction (sampled in IDLE or DONE only)
//   a, b     : minuend / subtrahend, sampled when start is accepted
//   busy     : high while bits are being shifted
//   done     : one-cycle pulse in the cycle the result is first visible
//   diff     : a - b modulo 2^WIDTH, held until the next result
//   borrow   : final borrow out (unsigned a < b)
//   overflow : signed overflow of a - b

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] sd_next;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts the LSB
  // computed first has walked down to bit 0.
  assign sd_next = {fs_d, sd_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sd_d       = sd_q;
    br_d       = br_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sd_d = sd_next;
        br_d = fs_bout;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the result, including the bit formed now.
          // Overflow is only possible when the operand signs differ.
          diff_d     = sd_next;
          borrow_d   = fs_bout;
          overflow_d = (a_msb_q != b_msb_q) && (sd_next[WIDTH-1] != a_msb_q);
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      sd_q       <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sd_q       <= sd_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  // Status decoded from the state register, so busy and done are
  // mutually exclusive and glitch-free.
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor

module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic ref_sub(input int ua, input int ub,
                         output int e_diff, output int e_borrow, output int e_ovf);
    int sa;
    int sb;
    int r;
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    r  = sa - sb;
    e_diff   = (ua - ub) & ((1 << W) - 1);
    e_borrow = (ua < ub) ? 1 : 0;
    e_ovf    = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
  endtask

  // Run one operation from IDLE. Cycle k is the k-th rising edge after
  // the accepting edge; values are sampled on the falling edge before it.
  // poke_k > 0 re-asserts start with a=b=all-ones just before edge poke_k.
  task automatic check_op(input string name, input int ia, input int ib,
                          input int e_diff, input int e_borrow, input int e_ovf,
                          input int poke_k);
    logic [W-1:0] d0;
    logic         b0;
    logic         o0;
    int done_edge;
    int busy_cnt;
    int unstable;
    int both;
    @(negedge clk);
    a = W'(ia);
    b = W'(ib);
    start = 1'b1;
    d0 = diff;
    b0 = borrow;
    o0 = overflow;
    done_edge = -1;
    busy_cnt = 0;
    unstable = 0;
    both = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (busy && done) both++;
      if (done) begin
        done_edge = k;
        break;
      end
      if (busy) busy_cnt++;
      if (diff !== d0 || borrow !== b0 || overflow !== o0) unstable++;
      if (poke_k > 0 && k == poke_k - 1) begin
        start = 1'b1;
        a = '1;
        b = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, " done_edge"}, done_edge, W + 1);
    check({name, " busy_cycles"}, busy_cnt, W);
    check({name, " held_before_done"}, unstable, 0);
    check({name, " busy_and_done"}, both, 0);
    check({name, " diff"}, int'(diff), e_diff);
    check({name, " borrow"}, int'(borrow), e_borrow);
    check({name, " overflow"}, int'(overflow), e_ovf);
    @(negedge clk);
    check({name, " done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int done_times[$];
    int ed;
    int eb;
    int eo;
    int ra;
    int rb;
    int n_done;
    int n_busy;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{a: 4'h7, b: 4'h3, diff: 4'h4, borrow: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 4'h3, b: 4'h7, diff: 4'hC, borrow: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 4'h8, b: 4'h1, diff: 4'h7, borrow: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 4'h9, b: 4'h9, diff: 4'h0, borrow: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 4'h2, b: 4'h5, diff: 4'hD, borrow: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 4'h7, b: 4'h8, diff: 4'hF, borrow: 1'b1, ovf: 1'b1};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset diff", int'(diff), 0);
    check("reset borrow", int'(borrow), 0);
    check("reset overflow", int'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      check_op($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b),
               int'(vecs[i].diff), int'(vecs[i].borrow), int'(vecs[i].ovf), 0);
    end

    // start re-pulsed mid-SHIFT with all-ones operands must be ignored
    check_op("ignore_start", 5, 2, 3, 0, 0, 3);

    // start held high: back-to-back results every W+1 cycles
    @(negedge clk);
    a = 4'h9;
    b = 4'h9;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_times.push_back(c);
        if (done_times.size() == 1) begin
          check("b2b first diff", int'(diff), 0);
          check("b2b first borrow", int'(borrow), 0);
          a = 4'h2;
          b = 4'h5;
        end else if (done_times.size() == 2) begin
          check("b2b second diff", int'(diff), 'hD);
          check("b2b second borrow", int'(borrow), 1);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b done count", done_times.size(), 2);
    if (done_times.size() == 2) begin
      check("b2b first done edge", done_times[0], W + 1);
      check("b2b period", done_times[1] - done_times[0], W + 1);
    end

    // reset during the 2nd SHIFT cycle; previous diff (0xD) is non-zero
    @(negedge clk);
    a = 4'h6;
    b = 4'h1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort diff", int'(diff), 0);
    check("abort borrow", int'(borrow), 0);
    check("abort overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("abort no_done", n_done, 0);
    check("abort idle", n_busy, 0);
    check_op("after_abort", 6, 1, 5, 0, 0, 0);

    // randomized operands against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      ref_sub(ra, rb, ed, eb, eo);
      check_op($sformatf("rand%0d a=%0h b=%0h", i, ra, rb), ra, rb, ed, eb, eo, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor. Computes `A − B` one bit per clock using a single full-subtractor cell, the inverse operation to the switch-driven ripple adder path. Operands are captured on a start handshake. The difference, borrow and signed overflow are held on registered outputs for the board LED/top-level wrapper to display.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..32.
- `clk`, input, 1: single system clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to begin a subtraction. Sampled only in IDLE or DONE.
- `a`, input, WIDTH: minuend. Sampled on the cycle `start` is accepted.
- `b`, input, WIDTH: subtrahend. Sampled on the cycle `start` is accepted.
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: one-cycle pulse; the result registers updated on this cycle.
- `diff`, output, WIDTH: `A − B` modulo 2^WIDTH. Holds its value until the next result.
- `borrow`, output, 1: final borrow-out; 1 iff unsigned `a < b`.
- `overflow`, output, 1: signed overflow of `A − B`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 → latch `a` into shift register SA and `b` into SB.
  - Clear the running borrow `br` and bit counter `cnt`.
  - Save `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow computation.
  - Go to SHIFT.
  - `start`=0 → stay in IDLE.
- SHIFT (each cycle):
  - Full-subtractor inputs: `x`=SA[0], `y`=SB[0], `bin`=`br`.
  - `d` = x ^ y ^ bin.
  - `bout` = (~x & y) | (~(x ^ y) & bin).
  - Shift `d` into the MSB of the internal result shift register SD (right shift).
  - Right-shift SA and SB.
  - `br` ← `bout`; `cnt` ← `cnt`+1.
  - When `cnt` = WIDTH−1, go to DONE.
- Transition into DONE:
  - `diff` ← final SD contents, including the bit computed this cycle.
  - `borrow` ← final `bout`.
  - `overflow` ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb).
  - `done`=1 for exactly the one DONE cycle.
- DONE:
  - `start`=1 → accept new operands exactly as in IDLE and go to SHIFT. This allows back-to-back operations.
  - Otherwise go to IDLE.
- `start` while in SHIFT is ignored: no re-latch and no queueing.
- `cnt` width is $clog2(WIDTH). It must not wrap before reaching WIDTH−1.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0, `overflow`=0.
  - SA, SB, SD, `br` and `cnt` all = 0.
- Reset asserted mid-SHIFT aborts the operation immediately. No `done` is produced. `diff`, `borrow` and `overflow` return to 0.
- Latency:
  - Start accepted at edge 0.
  - `busy` is high for WIDTH cycles, edges 1..WIDTH.
  - `done` is high during the cycle after edge WIDTH+1; 4-bit case: 5 edges after acceptance.
- Throughput: one result per WIDTH+1 cycles with `start` held high.
- `diff`, `borrow` and `overflow` change only on the edge entering DONE. They are stable at all other times.
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package `serial_sub_pkg`:
  - FSM state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Minimum/maximum WIDTH constants.
- One sub-module, `full_subtractor`: purely combinational, ports `x`, `y`, `bin`, `d`, `bout`. Instantiated once.
- The top level holds the FSM, the shift registers, the counter and the result registers.

## Test plan
All scenarios use WIDTH=4.
- a=7, b=3, start pulse → `done` 5 edges later; `diff`=4, `borrow`=0, `overflow`=0; `busy` high exactly 4 cycles.
- a=3, b=7 → `diff`=0xC, `borrow`=1, `overflow`=0.
- a=0x8, b=0x1 (−8 − 1) → `diff`=0x7, `borrow`=0, `overflow`=1.
- a=5, b=2, then `start` re-pulsed with a=0xF, b=0xF during SHIFT → new request ignored; result `diff`=3; outputs unchanged until that `done`.
- `start` held high with a=9, b=9 → `diff`=0 and `done` every 5 cycles; a/b changed to 2/5 mid-stream → next result `diff`=0xD, `borrow`=1.
- a=6, b=1, `rst_n` pulsed low at the 2nd SHIFT cycle → all outputs 0 immediately, state IDLE, no `done`; a following a=6, b=1 start gives `diff`=5.
